// File: rtl/fpu_pkg.sv
// Shared single-precision constants and the int-to-float FSM encoding.
package fpu_pkg;
  localparam int FP_EXP_W     = 8;
  localparam int FP_MANT_W    = 23;
  localparam int FP_BIAS      = 127;
  // Bias plus 31: exponent of a 32-bit magnitude whose MSB sits at bit 31.
  localparam int I2F_EXP_BASE = FP_BIAS + 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_e;
endpackage

// File: rtl/fp_round_nearest_even.sv
// Combinational round-to-nearest-even of a normalised single-precision value.
// I2F_INEXACT_FLAG_EN selects whether the inexact flag is computed or tied to 0.
module fp_round_nearest_even
  import fpu_pkg::*;
(
  input  logic [FP_EXP_W-1:0]  exp_in,
  input  logic [FP_MANT_W-1:0] mant_in,
  input  logic                 g,
  input  logic                 s,
  output logic [FP_EXP_W-1:0]  exp_out,
  output logic [FP_MANT_W-1:0] mant_out,
  output logic                 inexact
);
  logic             round_up;
  logic [FP_MANT_W:0] mant_inc;

  assign round_up = g & (s | mant_in[0]);
  assign mant_inc = {1'b0, mant_in} + {{FP_MANT_W{1'b0}}, round_up};

  // A carry-out leaves the low bits all zero, which is the wrapped mantissa.
  assign mant_out = mant_inc[FP_MANT_W-1:0];
  assign exp_out  = exp_in + {{(FP_EXP_W-1){1'b0}}, mant_inc[FP_MANT_W]};

`ifdef I2F_INEXACT_FLAG_EN
  assign inexact = g | s;
`else
  assign inexact = 1'b0;
`endif
endmodule

// File: rtl/int_to_float_converter.sv
// Multi-cycle fcvt.s.w / fcvt.s.wu: normalise by shifting, then round to nearest even.
// I2F_INEXACT_FLAG_EN enables the INEXACT flag; otherwise the port is tied to 0.
module int_to_float_converter
  import fpu_pkg::*;
#(
  parameter int NORM_STEP = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] DATA1,
  input  logic        UNSIGNED,
  output logic        BUSY,
  output logic        VALID,
  output logic [31:0] RESULT,
  output logic        INEXACT
);
  i2f_state_e state_q, state_d;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [5:0]  sh_q;
  logic        neg_in;
  logic [31:0] abs_in;
  logic        norm_wide;

  logic [FP_EXP_W-1:0]  exp_pre, rnd_exp;
  logic [FP_MANT_W-1:0] rnd_mant;
  logic                 rnd_inexact;

  assign neg_in    = ~UNSIGNED & DATA1[31];
  assign abs_in    = neg_in ? (32'd0 - DATA1) : DATA1;
  // Take the wide step only when it cannot push the leading one off the top.
  assign norm_wide = (mag_q[31 -: NORM_STEP] == '0);

  assign BUSY  = (state_q != IDLE);
  assign VALID = (state_q == DONE);

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (START) state_d = NORM;
      NORM: begin
        if (mag_q == '0)   state_d = DONE;
        else if (mag_q[31]) state_d = ROUND;
      end
      ROUND: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      sh_q   <= '0;
      RESULT <= '0;
    end else begin
      case (state_q)
        IDLE: if (START) begin
          sign_q <= neg_in;
          mag_q  <= abs_in;
          sh_q   <= '0;
        end
        NORM: begin
          if (mag_q == '0) begin
            RESULT <= '0;
          end else if (!mag_q[31]) begin
            mag_q <= norm_wide ? (mag_q << NORM_STEP) : (mag_q << 1);
            sh_q  <= sh_q + (norm_wide ? 6'(NORM_STEP) : 6'd1);
          end
        end
        ROUND: RESULT <= {sign_q, rnd_exp, rnd_mant};
        default: ;
      endcase
    end
  end

  assign exp_pre = 8'(I2F_EXP_BASE) - {2'b00, sh_q};

  fp_round_nearest_even u_round (
    .exp_in   (exp_pre),
    .mant_in  (mag_q[30:8]),
    .g        (mag_q[7]),
    .s        (|mag_q[6:0]),
    .exp_out  (rnd_exp),
    .mant_out (rnd_mant),
    .inexact  (rnd_inexact)
  );

`ifdef I2F_INEXACT_FLAG_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N)                            INEXACT <= 1'b0;
    else if (state_q == NORM && mag_q == '0) INEXACT <= 1'b0;
    else if (state_q == ROUND)               INEXACT <= rnd_inexact;
  end
`else
  logic inexact_unused;
  assign inexact_unused = rnd_inexact;
  assign INEXACT        = 1'b0;
`endif
endmodule

// File: tb/tb_int_to_float_converter.sv
// Directed bench for int_to_float_converter: arithmetic reference model plus scoreboard.
module tb_int_to_float_converter;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DATA1 = '0;
  logic        UNSIGNED = 1'b0;
  logic        BUSY, VALID, INEXACT;
  logic [31:0] RESULT;

`ifdef I2F_INEXACT_FLAG_EN
  localparam bit INX_EN = 1'b1;
`else
  localparam bit INX_EN = 1'b0;
`endif

  int_to_float_converter #(.NORM_STEP(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .DATA1(DATA1), .UNSIGNED(UNSIGNED),
    .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT), .INEXACT(INEXACT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] result;
    logic        inexact;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference conversion done on a wide integer: find the MSB, divide, round on the remainder.
  function automatic void model(input logic [31:0] d, input logic u,
                                output logic [31:0] r, output logic inx, output int lat);
    longint unsigned m, q, rem, half;
    int p, e, dr;
    logic s;
    s = !u && d[31];
    m = s ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    r = '0; inx = 1'b0; lat = 1;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e   = 127 + p;
    lat = (31 - p) + 2;
    rem = 0;
    if (p <= 23) q = m << (23 - p);
    else begin
      dr   = p - 23;
      q    = m >> dr;
      rem  = m - (q << dr);
      half = 64'd1 << (dr - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    inx = (rem != 0);
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    r = {s, 8'(e), 23'(q)};
  endfunction

  // Scoreboard: every VALID must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (VALID) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got VALID=1, expected 0 (result %h)", RESULT);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("cmp_result", RESULT, e.result);
        chk("cmp_inexact", 32'(INEXACT), INX_EN ? 32'(e.inexact) : 32'd0);
        chk("cmp_latency", 32'(cyc - e.start_edge), 32'(e.lat));
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic u, input int edge_no);
    exp_t e;
    model(d, u, e.result, e.inexact, e.lat);
    e.start_edge = edge_no;
    expq.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (BUSY && n < 200) begin @(negedge CLK); n++; end
    if (BUSY) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got BUSY=1 after %0d cycles, expected 0", nm, n);
    end
  endtask

  task automatic op(input string nm, input logic [31:0] d, input logic u,
                    input logic [31:0] lit_res, input logic lit_inx, input int lit_lat);
    logic [31:0] mr; logic mi; int ml;
    model(d, u, mr, mi, ml);
    chk({nm, "_model_res"}, mr, lit_res);
    chk({nm, "_model_inx"}, 32'(mi), 32'(lit_inx));
    chk({nm, "_model_lat"}, 32'(ml), 32'(lit_lat));
    @(negedge CLK);
    DATA1 = d; UNSIGNED = u; START = 1'b1;
    push_exp(d, u, cyc + 1);
    @(negedge CLK);
    START = 1'b0;
    wait_idle(nm);
    chk({nm, "_res"}, RESULT, lit_res);
    chk({nm, "_inx"}, 32'(INEXACT), INX_EN ? 32'(lit_inx) : 32'd0);
    chk({nm, "_pending"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_inexact", 32'(INEXACT), 32'd0);
    RESET_N = 1'b1;

    op("one",       32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 33);
    op("m1_s",      32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0, 33);
    op("max_u",     32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 1'b1, 2);
    op("tie_even",  32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 9);
    op("tie_odd",   32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 9);
    op("carry",     32'h7FFF_FFFF, 1'b0, 32'h4F00_0000, 1'b1, 3);
    op("min_s",     32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0, 2);
    op("min_u",     32'h8000_0000, 1'b1, 32'h4F00_0000, 1'b0, 2);
    op("exact24",   32'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF, 1'b0, 10);
    op("zero",      32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1);

    // START pulses while busy must not disturb the conversion in flight.
    @(negedge CLK);
    DATA1 = 32'h0001_0000; UNSIGNED = 1'b0; START = 1'b1;
    push_exp(32'h0001_0000, 1'b0, cyc + 1);
    @(negedge CLK); START = 1'b0;
    repeat (3) @(negedge CLK);
    DATA1 = 32'h1234_5678; START = 1'b1;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    wait_idle("busy_ign");
    chk("busy_ign_res", RESULT, 32'h4780_0000);
    chk("busy_ign_pending", 32'(expq.size()), 32'd0);

    // START held across the DONE cycle is taken only on the following IDLE edge.
    @(negedge CLK);
    DATA1 = 32'h0000_0003; UNSIGNED = 1'b1; START = 1'b1;
    push_exp(32'h0000_0003, 1'b1, cyc + 1);
    @(negedge CLK); START = 1'b0;
    begin
      int n = 0;
      while (!VALID && n < 100) begin @(negedge CLK); n++; end
      chk("done_wait_valid", 32'(VALID), 32'd1);
    end
    DATA1 = 32'hFFFF_FFFF; UNSIGNED = 1'b0; START = 1'b1;
    push_exp(32'hFFFF_FFFF, 1'b0, cyc + 2);
    @(negedge CLK);
    chk("done_ign_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    chk("idle_acc_busy", 32'(BUSY), 32'd1);
    wait_idle("done_start");
    chk("done_start_res", RESULT, 32'hBF80_0000);
    chk("done_start_pending", 32'(expq.size()), 32'd0);

    // Reset mid-normalise, with START asserted on the reset edge.
    @(negedge CLK);
    DATA1 = 32'h0000_0001; UNSIGNED = 1'b0; START = 1'b1;
    push_exp(32'h0000_0001, 1'b0, cyc + 1);
    @(negedge CLK); START = 1'b0;
    repeat (4) @(negedge CLK);
    RESET_N = 1'b0; START = 1'b1; DATA1 = 32'h7FFF_FFFF;
    expq.delete();
    @(negedge CLK);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_valid", 32'(VALID), 32'd0);
    chk("mid_rst_result", RESULT, 32'd0);
    chk("mid_rst_inexact", 32'(INEXACT), 32'd0);
    RESET_N = 1'b1; START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("post_rst_idle", 32'(BUSY), 32'd0);
    op("after_rst", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 33);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/int_to_float_converter.md
INT_TO_FLOAT_CONVERTER -- requirements
Module: int_to_float_converter

Interface
REQ-001 SHALL have parameter NORM_STEP, default 1, the maximum left-shift distance per normalise cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port START, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have port DATA1, input, 32 bits: integer operand, sampled on the START edge.
REQ-006 SHALL have port UNSIGNED, input, 1 bit: 1 = fcvt.s.wu (unsigned operand), 0 = fcvt.s.w (two's complement), sampled with DATA1.
REQ-007 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port VALID, output, 1 bit: one-cycle pulse marking RESULT as new.
REQ-009 SHALL have port RESULT, output, 32 bits: IEEE-754 single-precision result, held until the next accepted START.
REQ-010 SHALL have port INEXACT, output, 1 bit: rounding discarded non-zero bits, held with RESULT.

Function
REQ-011 SHALL implement FSM states IDLE, NORM, ROUND and DONE.
REQ-012 In IDLE with START=1, SHALL register SIGN = ~UNSIGNED & DATA1[31] and MAG = |DATA1| (32-bit, unsigned), clear the shift count SH, and go to NORM.
REQ-013 In NORM, if MAG==0, SHALL set RESULT=0x00000000 and INEXACT=0 and go to DONE.
REQ-014 In NORM, if MAG[31]==1, SHALL go to ROUND.
REQ-015 Otherwise in NORM, SHALL shift MAG left by NORM_STEP if MAG[31:32-NORM_STEP]==0, else by 1, and add the shift to SH.
REQ-016 In ROUND, SHALL compute exponent = 158 − SH, mantissa = MAG[30:8], guard G = MAG[7], sticky S = |MAG[6:0].
REQ-017 Rounding SHALL be round-to-nearest-even: increment the mantissa when G & (S | mantissa[0]).
REQ-018 On mantissa carry-out, SHALL set mantissa to 0 and increment the exponent.
REQ-019 SHALL form RESULT = {SIGN, exponent, mantissa}, set INEXACT = G | S, and go to DONE.
REQ-020 In DONE, SHALL drive VALID=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency: VALID SHALL be high lz/NORM_STEP + 2 edges after the START edge when NORM_STEP=1 (lz = leading zeros of MAG), and 1 edge after it for a zero operand.
REQ-022 START while BUSY=1 SHALL be ignored; the operation in flight is unaffected.
REQ-023 START in the DONE cycle SHALL be ignored; START in the following IDLE cycle SHALL be accepted.
REQ-024 The signed operand 0x80000000 SHALL yield MAG=0x80000000 and RESULT=0xCF000000.
REQ-025 The block SHALL never produce NaN, infinity or subnormal results.

Reset
REQ-026 RESET_N=0 at a rising edge SHALL force IDLE and set BUSY=0, VALID=0, RESULT=0 and INEXACT=0, including mid-operation; the aborted operation SHALL never assert VALID.
REQ-027 START SHALL be ignored on any edge where RESET_N=0.

Configuration
REQ-028 Macro I2F_INEXACT_FLAG_EN SHALL control the INEXACT flag.
REQ-029 With I2F_INEXACT_FLAG_EN defined, INEXACT SHALL behave per REQ-019.
REQ-030 Without I2F_INEXACT_FLAG_EN, the port SHALL remain and be tied to 0, and the G|S flag logic SHALL be removed; RESULT and timing SHALL be unchanged.

Structure
REQ-031 Shared package fpu_pkg SHALL hold FP_EXP_W=8, FP_MANT_W=23, FP_BIAS=127, I2F_EXP_BASE=158 and the FSM state encoding.
REQ-032 Rounding SHALL live in one combinational sub-module, fp_round_nearest_even (inputs: exponent, mantissa, G, S; outputs: rounded exponent, mantissa, inexact).

Verification
REQ-033 Scenario: DATA1=0x00000001, UNSIGNED=0, NORM_STEP=1 -> RESULT=0x3F800000, INEXACT=0, VALID 33 edges after START.
REQ-034 Scenario: DATA1=0xFFFFFFFF with UNSIGNED=0 -> RESULT=0xBF800000; the same DATA1 with UNSIGNED=1 -> RESULT=0x4F800000, INEXACT=1.
REQ-035 Scenario: DATA1=0x01000001 -> RESULT=0x4B800000 (tie rounds to even), INEXACT=1; DATA1=0x01000003 -> RESULT=0x4B800002, INEXACT=1.
REQ-036 Scenario: DATA1=0x7FFFFFFF -> RESULT=0x4F000000 (mantissa carry), INEXACT=1; DATA1=0x80000000 signed -> RESULT=0xCF000000, INEXACT=0.
REQ-037 Scenario: DATA1=0 -> RESULT=0x00000000 with VALID 1 edge after START; START re-asserted while BUSY -> ignored, only one VALID pulse.
REQ-038 Scenario: RESET_N=0 for one edge during NORM -> IDLE on the next cycle, all outputs 0, no VALID pulse; a fresh START then completes normally.
